// File: rtl/mips_register_file.sv
// 32x32 MIPS general-purpose register file: two combinational read
// ports, one synchronous write port, $0 hardwired to zero.

module rf_mux2 #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sel,
   output logic [W-1:0] y
);

   assign y = sel ? b : a;

endmodule

module rf_read_port #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic [DW-1:0] leaves [2**AW],
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] data
);

   localparam int DEPTH = 2**AW;

   // Heap-ordered tree: node k has children 2k/2k+1, leaves at DEPTH+i
   logic [DW-1:0] node [1:2*DEPTH-1];

   for (genvar i = 0; i < DEPTH; i++) begin : g_leaf
      assign node[DEPTH+i] = leaves[i];
   end

   for (genvar lv = 0; lv < AW; lv++) begin : g_lvl
      for (genvar j = 0; j < 2**lv; j++) begin : g_node
         rf_mux2 #(.W(DW)) u_mux (
            .a   (node[2*(2**lv+j)]),
            .b   (node[2*(2**lv+j)+1]),
            .sel (addr[AW-1-lv]),
            .y   (node[2**lv+j])
         );
      end
   end

   assign data = node[1];

endmodule

module mips_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  reg_write,
   input  logic [ADDR_WIDTH-1:0] write_reg,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_reg1,
   input  logic [ADDR_WIDTH-1:0] read_reg2,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [1:DEPTH-1];
   logic [DATA_WIDTH-1:0] regs_d [1:DEPTH-1];
   logic [DEPTH-1:0]      wr_en;
   logic [DATA_WIDTH-1:0] rd_leaf [DEPTH];

   always_comb begin
      wr_en = '0;
      if (reg_write && (write_reg != '0)) begin
         wr_en[write_reg] = 1'b1;
      end
   end

   always_comb begin
      regs_d = regs_q;
      for (int i = 1; i < DEPTH; i++) begin
         if (wr_en[i]) begin
            regs_d[i] = write_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 1; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // $0 has no storage; its mux leaf is a constant zero
   assign rd_leaf[0] = '0;
   for (genvar i = 1; i < DEPTH; i++) begin : g_rd_leaf
      assign rd_leaf[i] = regs_q[i];
   end

   rf_read_port #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_rd1 (
      .leaves (rd_leaf),
      .addr   (read_reg1),
      .data   (read_data1)
   );

   rf_read_port #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_rd2 (
      .leaves (rd_leaf),
      .addr   (read_reg2),
      .data   (read_data2)
   );

endmodule

// File: tb/tb_mips_register_file.sv
// Directed self-checking bench for mips_register_file.

module tb_mips_register_file;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [4:0]  read_reg1;
   logic [4:0]  read_reg2;
   logic [31:0] read_data1;
   logic [31:0] read_data2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mips_register_file dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .read_data1 (read_data1),
      .read_data2 (read_data2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      reg_write = 1'b1;
      write_reg = a;
      write_data = d;
      tick();
      reg_write = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wr(5'd5, 32'hDEADBEEF);
      read_reg1 = 5'd5;
      #1;
      checks++;
      if (read_data1 !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL preload_r5 got=%h exp=%h", read_data1, 32'hDEADBEEF);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (read_data1 !== 32'h0) begin
         failures++;
         $display("FAIL reset_r5 got=%h exp=0", read_data1);
      end
      for (int i = 1; i < 32; i++) begin
         read_reg1 = 5'(i);
         read_reg2 = 5'(i);
         #1;
         checks++;
         if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_clear r%0d got=%h/%h exp=0",
                     i, read_data1, read_data2);
         end
      end
   endtask

   task automatic test_basic_write();
      wr(5'd8, 32'h12345678);
      read_reg1 = 5'd8;
      #1;
      checks++;
      if (read_data1 !== 32'h12345678) begin
         failures++;
         $display("FAIL write_r8 got=%h exp=%h", read_data1, 32'h12345678);
      end
      wr(5'd9, 32'hA5A5A5A5);
      read_reg2 = 5'd9;
      #1;
      checks++;
      if (read_data2 !== 32'hA5A5A5A5) begin
         failures++;
         $display("FAIL write_r9 got=%h exp=%h", read_data2, 32'hA5A5A5A5);
      end
      checks++;
      if (read_data1 !== 32'h12345678) begin
         failures++;
         $display("FAIL port1_hold_r8 got=%h exp=%h",
                  read_data1, 32'h12345678);
      end
   endtask

   task automatic test_zero_reg();
      read_reg1 = 5'd0;
      read_reg2 = 5'd0;
      reg_write = 1'b1;
      write_reg = 5'd0;
      write_data = 32'hFFFFFFFF;
      #1;
      checks++;
      if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
         failures++;
         $display("FAIL r0_before got=%h/%h exp=0", read_data1, read_data2);
      end
      tick();
      reg_write = 1'b0;
      checks++;
      if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
         failures++;
         $display("FAIL r0_after got=%h/%h exp=0", read_data1, read_data2);
      end
      read_reg1 = 5'd8;
      #1;
      checks++;
      if (read_data1 !== 32'h12345678) begin
         failures++;
         $display("FAIL r0_write_alias_r8 got=%h exp=%h",
                  read_data1, 32'h12345678);
      end
   endtask

   task automatic test_write_disabled();
      wr(5'd3, 32'h00000011);
      read_reg1 = 5'd3;
      reg_write = 1'b0;
      write_reg = 5'd3;
      write_data = 32'h0000BEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (read_data1 !== 32'h00000011) begin
            failures++;
            $display("FAIL wr_disabled_r3 edge%0d got=%h exp=%h",
                     i, read_data1, 32'h00000011);
         end
      end
   endtask

   task automatic test_read_during_write();
      wr(5'd12, 32'h00000001);
      read_reg1 = 5'd12;
      reg_write = 1'b1;
      write_reg = 5'd12;
      write_data = 32'h00000002;
      #1;
      checks++;
      if (read_data1 !== 32'h00000001) begin
         failures++;
         $display("FAIL rdw_before got=%h exp=%h", read_data1, 32'h1);
      end
      tick();
      reg_write = 1'b0;
      checks++;
      if (read_data1 !== 32'h00000002) begin
         failures++;
         $display("FAIL rdw_after got=%h exp=%h", read_data1, 32'h2);
      end
   endtask

   task automatic test_reset_collision();
      wr(5'd31, 32'h31313131);
      rst_n = 1'b0;
      reg_write = 1'b1;
      write_reg = 5'd31;
      write_data = 32'hCAFEF00D;
      tick();
      rst_n = 1'b1;
      reg_write = 1'b0;
      read_reg1 = 5'd31;
      #1;
      checks++;
      if (read_data1 !== 32'h0) begin
         failures++;
         $display("FAIL rst_vs_write_r31 got=%h exp=0", read_data1);
      end
   endtask

   task automatic test_walk();
      logic [31:0] v1;
      logic [31:0] v2;
      for (int i = 1; i < 32; i++) begin
         wr(5'(i), 32'hA0000000 + 32'(i) * 32'h00010101);
      end
      for (int i = 0; i < 32; i++) begin
         read_reg1 = 5'(i);
         read_reg2 = 5'(31 - i);
         v1 = (i == 0) ? 32'h0 : 32'hA0000000 + 32'(i) * 32'h00010101;
         v2 = (i == 31) ? 32'h0
                        : 32'hA0000000 + 32'(31 - i) * 32'h00010101;
         #1;
         checks++;
         if (read_data1 !== v1 || read_data2 !== v2) begin
            failures++;
            $display("FAIL walk i=%0d got=%h/%h exp=%h/%h",
                     i, read_data1, read_data2, v1, v2);
         end
      end
   endtask

   initial begin
      rst_n = 1'b1;
      reg_write = 1'b0;
      write_reg = '0;
      write_data = '0;
      read_reg1 = '0;
      read_reg2 = '0;
      test_reset();
      test_basic_write();
      test_zero_reg();
      test_write_disabled();
      test_read_during_write();
      test_reset_collision();
      test_walk();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
